// File: rtl/mismatch_pkg.sv
// Shared definitions for mismatch_window_counter.
//   state_e : FSM state encoding (IDLE / RUN / DONE)
//   clog2   : constant ceil(log2(value)) used to size the count and sample counter
package mismatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of bits needed to index `value` distinct items; clog2(N+1) holds N.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_qual.sv
// One lane of the mismatch gate: f = (a ^ b) & (c | ~d), built from gate primitives.
// Ports:
//   a, b : operands compared for mismatch
//   c, d : qualifier; lane counts when c is set or d is clear
//   f    : combinational lane result
module lane_qual (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output wire  f
);

  wire x_ab;
  wire d_n;
  wire q_cd;

  xor g_x (x_ab, a, b);
  not g_n (d_n, d);
  or  g_o (q_cd, c, d_n);
  and g_a (f, x_ab, q_cd);

endmodule

// File: rtl/mismatch_window_counter.sv
// Evaluates the mismatch gate on WIDTH lanes each cycle, registers the lane result
// and accumulates asserted lanes over WINDOW valid samples, reporting a total and
// a threshold alarm at the end of each window.
// Ports:
//   Clock, Reset_b : rising-edge clock, synchronous active-low reset
//   start, abort   : begin a window (IDLE/DONE) / cancel a running window
//   in_valid       : A/B/C/D carry a sample this cycle
//   A, B, C, D     : lane operands
//   F              : registered lane result (zero when in_valid was low)
//   busy, done     : window running / one-cycle completion pulse
//   count, alarm   : total of last completed window and count >= THRESH
module mismatch_window_counter
  import mismatch_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 16,
  parameter int THRESH = 8,
  localparam int CNT_W = clog2(WIDTH * WINDOW + 1)
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] F,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  localparam int N_W = clog2(WINDOW + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc;
  logic [N_W-1:0]   n;
  logic [CNT_W-1:0] acc_sum;
  logic             last_sample;
  logic             accept_start;
  wire  [WIDTH-1:0] f_p0;

  // Stage p0: combinational lane evaluation
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lane_qual u_lane (
      .a (A[i]),
      .b (B[i]),
      .c (C[i]),
      .d (D[i]),
      .f (f_p0[i])
    );
  end

  assign acc_sum      = acc + popcount(f_p0);
  // This valid sample is the WINDOW-th one of the window.
  assign last_sample  = in_valid && (n == N_W'(WINDOW - 1));
  assign accept_start = start && !abort && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN: begin
        // abort on the final sample wins over completion
        if (abort)            state_d = IDLE;
        else if (last_sample) state_d = DONE;
      end
      DONE:    state_d = (start && !abort) ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered lane result, state, accumulator and window report
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      F       <= '0;
      acc     <= '0;
      n       <= '0;
      count   <= '0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      F       <= in_valid ? f_p0 : '0;
      if (accept_start) begin
        // the sample on the start cycle is not counted
        acc <= '0;
        n   <= '0;
      end else if (state_q == RUN && !abort && in_valid) begin
        acc <= acc_sum;
        n   <= n + N_W'(1);
        if (last_sample) begin
          count <= acc_sum;
          alarm <= (acc_sum >= CNT_W'(THRESH));
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mismatch_window_counter.sv
module tb_mismatch_window_counter;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 4;
  localparam int THRESH = 6;
  localparam int CNT_W  = 5;

  logic             Clock = 1'b0;
  logic             Reset_b;
  logic             start, abort, in_valid;
  logic [WIDTH-1:0] A, B, C, D;
  logic [WIDTH-1:0] F;
  logic             busy, done, alarm;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: a window is either open or not; done is a one-cycle report.
  logic [WIDTH-1:0] m_F;
  bit               m_open, m_done, m_alarm;
  int               m_count, m_seen, m_total;

  mismatch_window_counter #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .THRESH (THRESH)
  ) dut (
    .Clock    (Clock),
    .Reset_b  (Reset_b),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .F        (F),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .alarm    (alarm)
  );

  always #5 Clock = ~Clock;

  function automatic logic [WIDTH-1:0] lane_fn(input logic [WIDTH-1:0] a, b, c, d);
    return (a ^ b) & (c | ~d);
  endfunction

  function automatic int ones(input logic [WIDTH-1:0] v);
    int s = 0;
    for (int i = 0; i < WIDTH; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_F, m_open, m_done, CNT_W'(m_count), m_alarm};
  endfunction

  task automatic drive(input logic st, ab, v, input logic [WIDTH-1:0] a, b, c, d);
    start = st; abort = ab; in_valid = v; A = a; B = b; C = c; D = d;
  endtask

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    logic [WIDTH-1:0] f;
    f = lane_fn(A, B, C, D);
    @(posedge Clock);
    if (!Reset_b) begin
      m_F = '0; m_open = 0; m_done = 0; m_count = 0; m_alarm = 0;
      m_seen = 0; m_total = 0;
    end else begin
      m_F    = in_valid ? f : '0;
      m_done = 0;
      if (m_open) begin
        if (abort) m_open = 0;
        else if (in_valid) begin
          m_total += ones(f);
          m_seen++;
          if (m_seen == WINDOW) begin
            m_open  = 0;
            m_done  = 1;
            m_count = m_total;
            m_alarm = (m_total >= THRESH);
          end
        end
      end else if (start && !abort) begin
        m_open = 1; m_seen = 0; m_total = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset_b = 1'b0;
    drive(0, 0, 0, '0, '0, '0, '0);
    tick(); tick();
    checks++;
    if ({F, busy, done, count, alarm} !== 12'b0) begin
      errors++;
      $display("FAIL reset_init: got %b want %b", {F, busy, done, count, alarm}, 12'b0);
    end
    Reset_b = 1'b1;
    drive(1, 0, 0, '0, '0, '0, '0); tick();
    drive(0, 0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000); tick(); tick();
    checks++;
    if (busy !== 1'b1 || F !== 4'b1111) begin
      errors++;
      $display("FAIL reset_prerun: got busy=%b F=%b want busy=1 F=1111", busy, F);
    end
    Reset_b = 1'b0;
    tick(); tick();
    checks++;
    if ({F, busy, done, count, alarm} !== 12'b0) begin
      errors++;
      $display("FAIL reset_midrun: got %b want %b", {F, busy, done, count, alarm}, 12'b0);
    end
    Reset_b = 1'b1;
    drive(0, 0, 0, '0, '0, '0, '0); tick();
  endtask

  task automatic test_lane_function();
    drive(0, 0, 1, 4'b1010, 4'b0110, 4'b0001, 4'b1011); tick();
    checks++;
    if (F !== 4'b0100) begin
      errors++;
      $display("FAIL lane_f: got %b want %b", F, 4'b0100);
    end
    drive(0, 0, 0, 4'b1010, 4'b0110, 4'b0001, 4'b1011); tick();
    checks++;
    if (F !== 4'b0000) begin
      errors++;
      $display("FAIL lane_f_invalid: got %b want %b", F, 4'b0000);
    end
  endtask

  task automatic test_full_window();
    drive(1, 0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000); tick(); // start sample not counted
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_rise: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 4'b0011, 4'b0000, 4'b1111, 4'b0000); tick();
      checks++;
      if (busy !== (k < 4) || done !== (k == 4)) begin
        errors++;
        $display("FAIL full_seq%0d: got busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, (k < 4), (k == 4));
      end
    end
    checks++;
    if (count !== 5'd8 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL full_result: got count=%0d alarm=%b want count=8 alarm=1", count, alarm);
    end
    drive(0, 0, 0, '0, '0, '0, '0); tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 5'd8) begin
      errors++;
      $display("FAIL full_after: got done=%b busy=%b count=%0d want 0 0 8", done, busy, count);
    end
  endtask

  task automatic test_abort();
    drive(1, 0, 0, '0, '0, '0, '0); tick();
    drive(0, 0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000); tick(); tick();
    drive(0, 1, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 5'd8 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL abort_run: got busy=%b done=%b count=%0d alarm=%b want 0 0 8 1",
               busy, done, count, alarm);
    end
    drive(0, 0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_nodone%0d: got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    drive(1, 1, 0, '0, '0, '0, '0); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start: got busy=%b want 0", busy);
    end
    drive(0, 0, 0, '0, '0, '0, '0); tick();
  endtask

  task automatic test_gaps();
    drive(1, 0, 0, '0, '0, '0, '0); tick();
    for (int t = 1; t <= 7; t++) begin
      drive(0, 0, (t % 2) == 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000); tick();
      checks++;
      if (done !== (t == 7) || busy !== (t < 7)) begin
        errors++;
        $display("FAIL gaps_t%0d: got done=%b busy=%b want done=%b busy=%b",
                 t + 1, done, busy, (t == 7), (t < 7));
      end
    end
    checks++;
    if (count !== 5'd4 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: got count=%0d alarm=%b want count=4 alarm=0", count, alarm);
    end
    drive(0, 0, 0, '0, '0, '0, '0); tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, '0, '0, '0, '0); tick();
    drive(0, 0, 1, 4'b0011, 4'b0000, 4'b1111, 4'b0000);
    repeat (4) tick();
    checks++;
    if (done !== 1'b1 || count !== 5'd8) begin
      errors++;
      $display("FAIL b2b_first: got done=%b count=%0d want done=1 count=8", done, count);
    end
    // start in the DONE cycle; that cycle's sample is not counted
    drive(1, 0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000); tick();
    for (int k = 1; k <= 4; k++) begin
      drive(k % 2 == 1, 0, 1, 4'b1010, 4'b0101, 4'b1111, 4'b1111); tick();
      checks++;
      if (done !== (k == 4)) begin
        errors++;
        $display("FAIL b2b_seq%0d: got done=%b want %b", k, done, (k == 4));
      end
    end
    checks++;
    if (count !== 5'd16 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sat: got count=%0d alarm=%b want count=16 alarm=1", count, alarm);
    end
    drive(0, 0, 0, '0, '0, '0, '0); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      Reset_b = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      tick();
      checks++;
      if ({F, busy, done, count, alarm} !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %b want %b (F,busy,done,count,alarm)",
                 k, {F, busy, done, count, alarm}, model_vec());
      end
    end
    Reset_b = 1'b1;
  endtask

  // Directed scenarios also track the model so the random phase starts in sync.
  initial begin
    Reset_b = 1'b0;
    drive(0, 0, 0, '0, '0, '0, '0);
    m_F = '0; m_open = 0; m_done = 0; m_alarm = 0; m_count = 0; m_seen = 0; m_total = 0;
    test_reset();
    test_lane_function();
    test_full_window();
    test_abort();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
